array_allocator: RTL

ARRAY_ALLOCATOR -- requirements
Module: array_allocator

---
 rtl/fpga_pkg.sv | 21 ++
 rtl/freed_stack.sv | 61 ++++++
 rtl/array_allocator.sv | 133 +++++++++++++
 3 files changed

// File: rtl/fpga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpga_pkg
// Purpose  : Shared widths, default sizes and the array-number type used by
//            the array allocator and its freed-array stack.
// Revision : 1.0  initial release
// ============================================================================
package fpga_pkg;

  localparam int MEMORY_ELEMENT_WIDTH = 12;
  localparam int N_ARRAYS             = 200;

  typedef logic [MEMORY_ELEMENT_WIDTH-1:0] array_num_t;

  // Index width needed to address n entries (never zero, so n == 1 still works)
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/freed_stack.sv
`default_nettype none
// ============================================================================
// Module   : freed_stack
// Purpose  : LIFO of freed array numbers. Push and pop are mutually exclusive
//            by construction in the allocator; pop takes priority if both occur.
// Revision : 1.0  initial release
// ============================================================================
module freed_stack
  import fpga_pkg::*;
#(
  parameter int WIDTH = MEMORY_ELEMENT_WIDTH,
  parameter int DEPTH = N_ARRAYS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int SAW = idx_width(DEPTH);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count;
  logic             do_pop;
  logic             do_push;

  // Occupancy flags and the visible top-of-stack entry
  always_comb begin
    empty   = (count == '0);
    full    = (count == C_DEPTH);
    do_pop  = pop & ~empty;
    do_push = push & ~full & ~do_pop;
    top     = empty ? '0 : mem[SAW'(count - 1'b1)];
  end

  // Stack pointer: number of valid entries
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (do_pop) begin
      count <= count - 1'b1;
    end else if (do_push) begin
      count <= count + 1'b1;
    end
  end

  // Entry storage; contents are meaningless above the pointer so no reset
  always_ff @(posedge clock) begin
    if (!reset && do_push) begin
      mem[SAW'(count)] <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/array_allocator.sv
`default_nettype none
// ============================================================================
// Module   : array_allocator
// Purpose  : Hands out array numbers (recycled from a freed stack first, then
//            fresh ones), tracks a per-array size (max written index + 1) and
//            flags protocol errors. Optional macro
//            ARRAY_ALLOCATOR_DOUBLE_FREE_CHECK_EN adds an in-use bitmap that
//            rejects frees of arrays not currently allocated.
// Revision : 1.0  initial release
// ============================================================================
module array_allocator
  import fpga_pkg::*;
#(
  parameter int MemoryElementWidth = MEMORY_ELEMENT_WIDTH,
  parameter int NArrays            = N_ARRAYS
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          allocReq,
  output logic                          allocValid,
  output logic [MemoryElementWidth-1:0] allocArray,
  input  logic                          freeReq,
  input  logic [MemoryElementWidth-1:0] freeArray,
  input  logic                          sizeWr,
  input  logic [MemoryElementWidth-1:0] sizeArray,
  input  logic [MemoryElementWidth-1:0] sizeIndex,
  input  logic [MemoryElementWidth-1:0] sizeRdArray,
  output logic [MemoryElementWidth-1:0] sizeRdData,
  output logic                          exhausted,
  output logic [MemoryElementWidth-1:0] allocs,
  output logic                          error
);

  localparam int W  = MemoryElementWidth;
  localparam int AW = idx_width(NArrays);
  localparam logic [W-1:0] N_LIM = W'(NArrays);

  logic         stack_push, stack_pop, stack_empty, stack_full;
  logic [W-1:0] stack_top;
  logic         bypass, fresh_ok, free_legal, alloc_ok, alloc_fresh, proto_err;
  logic [W-1:0] alloc_num;
  logic [W-1:0] size_old, size_inc, size_new;
  logic [W-1:0] sizes [NArrays];

`ifdef ARRAY_ALLOCATOR_DOUBLE_FREE_CHECK_EN
  logic [NArrays-1:0] in_use;
`endif

  freed_stack #(
    .WIDTH (W),
    .DEPTH (NArrays)
  ) u_stack (
    .clock     (clock),
    .reset     (reset),
    .push      (stack_push),
    .push_data (freeArray),
    .pop       (stack_pop),
    .top       (stack_top),
    .empty     (stack_empty),
    .full      (stack_full)
  );

  // Request decode: bypass first, then recycled, then fresh allocation
  always_comb begin
    bypass      = allocReq & freeReq;
    fresh_ok    = (allocs != N_LIM);
    exhausted   = stack_empty & ~fresh_ok;
    free_legal  = (freeArray < allocs) & ~stack_full;
`ifdef ARRAY_ALLOCATOR_DOUBLE_FREE_CHECK_EN
    free_legal  = free_legal & in_use[AW'(freeArray)];
`endif
    alloc_ok    = bypass | (allocReq & ~exhausted);
    stack_pop   = allocReq & ~freeReq & ~stack_empty;
    stack_push  = freeReq & ~allocReq & free_legal;
    alloc_fresh = allocReq & ~freeReq & stack_empty & fresh_ok;
    alloc_num   = bypass ? freeArray : (stack_empty ? allocs : stack_top);
    proto_err   = (allocReq & ~freeReq & exhausted) |
                  (freeReq & ~allocReq & ~free_legal);
  end

  // Allocation result, high-water counter and sticky error flag
  always_ff @(posedge clock) begin
    if (reset) begin
      allocValid <= 1'b0;
      allocArray <= '0;
      allocs     <= '0;
      error      <= 1'b0;
    end else begin
      allocValid <= alloc_ok;
      if (alloc_ok)    allocArray <= alloc_num;
      if (alloc_fresh) allocs     <= allocs + 1'b1;
      if (proto_err)   error      <= 1'b1;
    end
  end

`ifdef ARRAY_ALLOCATOR_DOUBLE_FREE_CHECK_EN
  // In-use bitmap: allocation sets (including bypass), accepted free clears
  always_ff @(posedge clock) begin
    if (reset) begin
      in_use <= '0;
    end else begin
      if (stack_push) in_use[AW'(freeArray)] <= 1'b0;
      if (alloc_ok && (alloc_num < N_LIM)) in_use[AW'(alloc_num)] <= 1'b1;
    end
  end
`endif

  // Candidate size for a write: max(current, index + 1), wrapping at W bits
  always_comb begin
    size_old = sizes[AW'(sizeArray)];
    size_inc = sizeIndex + 1'b1;
    size_new = (size_inc > size_old) ? size_inc : size_old;
  end

  // Size table, kept across reset; an allocation clear overrides a same-cycle write
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (sizeWr && (sizeArray < N_LIM)) sizes[AW'(sizeArray)] <= size_new;
      if (alloc_ok && (alloc_num < N_LIM)) sizes[AW'(alloc_num)] <= '0;
    end
  end

  // Registered size read, showing the table before this cycle's updates
  always_ff @(posedge clock) begin
    if (reset) begin
      sizeRdData <= '0;
    end else begin
      sizeRdData <= (sizeRdArray < N_LIM) ? sizes[AW'(sizeRdArray)] : '0;
    end
  end

endmodule
`default_nettype wire
